// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two writeback requesters (ALU = req0, load = req1)
// onto the single register-file write port WE3/A3/WD3.
// Default build: fixed priority for req0, with a starvation guard that
// hands priority to req1 after STARVE_MAX consecutive losses.
// Define REGFILE_WB_RR_ARB_EN to select round-robin arbitration instead.
// In round-robin builds the loss counter is not built and starved is tied to 0.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              starved
);

  // The loss counter saturates at its 4-bit maximum instead of wrapping.
  // A wrap would silently drop starvation after 16 losses.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic              gnt0_p0;
  logic              gnt1_p0;
  logic              vld_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] data_p0;

`ifdef REGFILE_WB_RR_ARB_EN
  // prio_ptr names the requester that wins the next contention.
  // It flips away from whoever was granted last, so the last winner yields.
  logic prio_ptr;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] loss_cnt;
  logic [3:0] loss_cnt_nxt;
`endif

  // ---- stage p0: combinational grant and writeback select ----
  // Grant: a lone requester always wins.
  // On contention, the mode-specific rule picks the winner.
  // No grant is given while CLR is high.
  always_comb begin
    gnt0_p0 = 1'b0;
    gnt1_p0 = 1'b0;
    if (!CLR) begin
      if (req0_valid && req1_valid) begin
`ifdef REGFILE_WB_RR_ARB_EN
        gnt1_p0 = prio_ptr;
        gnt0_p0 = !prio_ptr;
`else
        gnt1_p0 = starved;
        gnt0_p0 = !starved;
`endif
      end else begin
        gnt0_p0 = req0_valid;
        gnt1_p0 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0_p0;
  assign req1_ready = gnt1_p0;
  assign vld_p0     = gnt0_p0 | gnt1_p0;
  assign addr_p0    = gnt1_p0 ? req1_addr : req0_addr;
  assign data_p0    = gnt1_p0 ? req1_data : req0_data;

`ifdef REGFILE_WB_RR_ARB_EN
  assign starved = 1'b0;

  // Round-robin pointer: move priority to the other requester after every grant.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      prio_ptr <= 1'b0;
    end else if (gnt0_p0) begin
      prio_ptr <= 1'b1;
    end else if (gnt1_p0) begin
      prio_ptr <= 1'b0;
    end
  end
`else
  // Next loss count: req1 loses when it waits while req0 is granted.
  // The count clears when req1 is served or has nothing pending.
  always_comb begin
    loss_cnt_nxt = loss_cnt;
    if (req1_valid && gnt0_p0) begin
      loss_cnt_nxt = sat_inc4(loss_cnt);
    end else if (gnt1_p0 || !req1_valid) begin
      loss_cnt_nxt = 4'd0;
    end
  end

  // Starvation guard.
  // starved is registered from the next count, so it is high in the cycle
  // right after the limit-th loss. It drops once req1 is granted.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      loss_cnt <= 4'd0;
      starved  <= 1'b0;
    end else begin
      loss_cnt <= loss_cnt_nxt;
      starved  <= (loss_cnt_nxt >= STARVE_LIM);
    end
  end
`endif

  // ---- stage p1: registered register-file write port ----
  // Writeback register.
  // WE3 pulses for one cycle per accepted non-zero address.
  // A3/WD3 hold their values when nothing is accepted.
  // Writes to address 0 are consumed but never enabled.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      WE3 <= 1'b0;
      A3  <= '0;
      WD3 <= '0;
    end else begin
      WE3 <= vld_p0 && (addr_p0 != '0);
      if (vld_p0) begin
        A3  <= addr_p0;
        WD3 <= data_p0;
      end
    end
  end

endmodule
